// File: rtl/s526a_tb_pkg.sv
// Shared definitions for the s526a response compactor and its stimulus side.
// Contents:
//   misr_state_e           - run-control FSM states
//   DefaultPoly/Seed       - x^16+x^5+x^3+x^2+1 taps (x^16 implied) and reset signature
//   RespWidth, RespG*      - response-vector width and bit position of each s526a output
//   pack_resp()            - assembles the response vector in that bit order
package s526a_tb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } misr_state_e;

  localparam logic [15:0] DefaultPoly = 16'h002D;
  localparam logic [15:0] DefaultSeed = 16'h0000;

  localparam int unsigned RespWidth = 6;
  localparam int unsigned RespG147  = 0;
  localparam int unsigned RespG148  = 1;
  localparam int unsigned RespG198  = 2;
  localparam int unsigned RespG199  = 3;
  localparam int unsigned RespG213  = 4;
  localparam int unsigned RespG214  = 5;

  function automatic logic [RespWidth-1:0] pack_resp(input logic g147, input logic g148,
                                                     input logic g198, input logic g199,
                                                     input logic g213, input logic g214);
    logic [RespWidth-1:0] r;
    r           = '0;
    r[RespG147] = g147;
    r[RespG148] = g148;
    r[RespG198] = g198;
    r[RespG199] = g199;
    r[RespG213] = g213;
    r[RespG214] = g214;
    return r;
  endfunction

endpackage

// File: rtl/misr_step.sv
// One combinational MISR step: shift left, fold in the feedback taps when the
// outgoing MSB is set, then XOR in the zero-extended response vector.
// Ports:
//   sig_i      - current signature (W bits)
//   r_i        - response vector (RespWidth bits, bit 0 = G147)
//   poly_i     - feedback taps, x^W term excluded
//   sig_next_o - signature after one step
module misr_step
  import s526a_tb_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0]         sig_i,
  input  logic [RespWidth-1:0] r_i,
  input  logic [W-1:0]         poly_i,
  output logic [W-1:0]         sig_next_o
);

  logic [W-1:0] r_ext;
  logic [W-1:0] fb;

  always_comb begin
    r_ext      = {{(W - RespWidth){1'b0}}, r_i};
    fb         = sig_i[W-1] ? poly_i : '0;
    sig_next_o = {sig_i[W-2:0], 1'b0} ^ fb ^ r_ext;
  end

endmodule

// File: rtl/s526a_resp_misr.sv
// Response compactor for the s526a benchmark outputs. Folds the six outputs into
// a W-bit MISR on every IN_VALID cycle of a run, stops after LEN captures and
// raises DONE with the signature frozen.
// Optional feature (macro S526A_MISR_CMP_EN): on entry to DONE the next
// signature is compared against GOLDEN and the result held on PASS. Without the
// macro PASS is tied low and GOLDEN is unused.
// Ports:
//   CK, RST          - clock, synchronous active-high reset
//   START            - begin a run (honoured in IDLE and DONE only)
//   IN_VALID         - current s526a outputs are a capture
//   G147..G214       - s526a primary outputs
//   BUSY, DONE       - run in progress / run complete
//   SIG              - current signature
//   CNT              - captures taken in the current run
//   PASS             - golden-compare result
// W must lie in 8..32 and LEN in 1..65535.
module s526a_resp_misr
  import s526a_tb_pkg::*;
#(
  parameter int unsigned    W      = 16,
  parameter logic [W-1:0]   POLY   = W'(DefaultPoly),
  parameter logic [W-1:0]   SEED   = W'(DefaultSeed),
  parameter int unsigned    LEN    = 256,
  parameter logic [W-1:0]   GOLDEN = '0
) (
  input  logic         CK,
  input  logic         RST,
  input  logic         START,
  input  logic         IN_VALID,
  input  logic         G147,
  input  logic         G148,
  input  logic         G198,
  input  logic         G199,
  input  logic         G213,
  input  logic         G214,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] SIG,
  output logic [15:0]  CNT,
  output logic         PASS
);

  localparam logic [15:0] LenCnt = 16'(LEN);

  misr_state_e          state_q, state_d;
  logic [W-1:0]         sig_q, sig_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [RespWidth-1:0] resp;
  logic [W-1:0]         sig_step;
  logic [15:0]          cnt_inc;
  logic                 start_take;
  logic                 capture;
  logic                 last_cap;

  assign resp = pack_resp(G147, G148, G198, G199, G213, G214);

  misr_step #(
    .W (W)
  ) u_step (
    .sig_i      (sig_q),
    .r_i        (resp),
    .poly_i     (POLY),
    .sig_next_o (sig_step)
  );

  // START wins over IN_VALID outside RUN; IN_VALID is only honoured in RUN.
  assign start_take = START && (state_q != StRun);
  assign capture    = IN_VALID && (state_q == StRun);
  assign cnt_inc    = cnt_q + 16'd1;
  assign last_cap   = capture && (cnt_inc == LenCnt);

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_take) begin
          state_d = StRun;
          sig_d   = SEED;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (capture) begin
          sig_d = sig_step;
          cnt_d = cnt_inc;
          if (last_cap) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= StIdle;
      sig_q   <= SEED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BUSY = (state_q == StRun);
  assign DONE = (state_q == StDone);
  assign SIG  = sig_q;
  assign CNT  = cnt_q;

`ifdef S526A_MISR_CMP_EN
  logic pass_q, pass_d;

  // Compare the value being written on the final capture so PASS lands with DONE.
  always_comb begin
    pass_d = pass_q;
    if (start_take) begin
      pass_d = 1'b0;
    end else if (last_cap) begin
      pass_d = (sig_step == GOLDEN);
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end

  assign PASS = pass_q;
`else
  logic unused_golden;
  assign unused_golden = ^GOLDEN;
  assign PASS          = 1'b0;
`endif

endmodule

// File: tb/tb_s526a_resp_misr.sv
// Directed bench for s526a_resp_misr (W=16, LEN=4). Three instances share one
// stimulus bus: dut (SEED=0, GOLDEN=0x0000), dut_bad (GOLDEN=0x01F9) and dut_fb
// (SEED=0x8000) for the feedback-tap case.
module tb_s526a_resp_misr;
  import s526a_tb_pkg::*;

`ifdef S526A_MISR_CMP_EN
  localparam bit CmpEn = 1'b1;
`else
  localparam bit CmpEn = 1'b0;
`endif

  logic        ck;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [5:0]  r_drv;
  logic        busy, done, pass;
  logic [15:0] sig, cnt;
  logic        busy_b, done_b, pass_b;
  logic [15:0] sig_b, cnt_b;
  logic        busy_f, done_f, pass_f;
  logic [15:0] sig_f, cnt_f;

  int n_checks = 0;
  int n_fail   = 0;

  initial ck = 1'b0;
  always #5 ck = ~ck;

  s526a_resp_misr #(
    .W      (16),
    .POLY   (16'h002D),
    .SEED   (16'h0000),
    .LEN    (4),
    .GOLDEN (16'h0000)
  ) dut (
    .CK       (ck),
    .RST      (rst),
    .START    (start),
    .IN_VALID (in_valid),
    .G147     (r_drv[RespG147]),
    .G148     (r_drv[RespG148]),
    .G198     (r_drv[RespG198]),
    .G199     (r_drv[RespG199]),
    .G213     (r_drv[RespG213]),
    .G214     (r_drv[RespG214]),
    .BUSY     (busy),
    .DONE     (done),
    .SIG      (sig),
    .CNT      (cnt),
    .PASS     (pass)
  );

  s526a_resp_misr #(
    .W      (16),
    .POLY   (16'h002D),
    .SEED   (16'h0000),
    .LEN    (4),
    .GOLDEN (16'h01F9)
  ) dut_bad (
    .CK       (ck),
    .RST      (rst),
    .START    (start),
    .IN_VALID (in_valid),
    .G147     (r_drv[RespG147]),
    .G148     (r_drv[RespG148]),
    .G198     (r_drv[RespG198]),
    .G199     (r_drv[RespG199]),
    .G213     (r_drv[RespG213]),
    .G214     (r_drv[RespG214]),
    .BUSY     (busy_b),
    .DONE     (done_b),
    .SIG      (sig_b),
    .CNT      (cnt_b),
    .PASS     (pass_b)
  );

  s526a_resp_misr #(
    .W      (16),
    .POLY   (16'h002D),
    .SEED   (16'h8000),
    .LEN    (4),
    .GOLDEN (16'h0000)
  ) dut_fb (
    .CK       (ck),
    .RST      (rst),
    .START    (start),
    .IN_VALID (in_valid),
    .G147     (r_drv[RespG147]),
    .G148     (r_drv[RespG148]),
    .G198     (r_drv[RespG198]),
    .G199     (r_drv[RespG199]),
    .G213     (r_drv[RespG213]),
    .G214     (r_drv[RespG214]),
    .BUSY     (busy_f),
    .DONE     (done_f),
    .SIG      (sig_f),
    .CNT      (cnt_f),
    .PASS     (pass_f)
  );

  typedef struct {
    logic        st;
    logic        iv;
    logic [5:0]  r;
    logic [15:0] sig;
    logic [15:0] cnt;
    logic        busy;
    logic        done;
    logic        pass;      // dut PASS if compare compiled in
    logic        pass_bad;  // dut_bad PASS if compare compiled in
  } vec_t;

  localparam int NVec = 18;
  vec_t tv[NVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs away from the edge, then sample just after it.
  task automatic drive(input logic st, input logic iv, input logic [5:0] r);
    @(negedge ck);
    start    = st;
    in_valid = iv;
    r_drv    = r;
    @(posedge ck);
    #1;
  endtask

  initial begin
    //            st    iv    r      sig       cnt     busy  done  pass  pass_bad
    tv[0]  = '{1'b0, 1'b1, 6'h3f, 16'h0000, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // IN_VALID in IDLE
    tv[1]  = '{1'b1, 1'b0, 6'h00, 16'h0000, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 6'h3f, 16'h003f, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 6'h2a, 16'h003f, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 6'h15, 16'h006b, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 6'h00, 16'h006b, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0}; // START in RUN
    tv[6]  = '{1'b0, 1'b1, 6'h2a, 16'h00fc, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b0, 6'h00, 16'h00fc, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 6'h01, 16'h01f9, 16'd4, 1'b0, 1'b1, 1'b0, 1'b1}; // final capture
    tv[9]  = '{1'b0, 1'b1, 6'h3f, 16'h01f9, 16'd4, 1'b0, 1'b1, 1'b0, 1'b1}; // frozen in DONE
    tv[10] = '{1'b1, 1'b1, 6'h3f, 16'h0000, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0}; // restart + IN_VALID
    tv[11] = '{1'b0, 1'b1, 6'h01, 16'h0001, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[12] = '{1'b0, 1'b0, 6'h3f, 16'h0001, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[13] = '{1'b0, 1'b1, 6'h02, 16'h0000, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[14] = '{1'b0, 1'b0, 6'h00, 16'h0000, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[15] = '{1'b0, 1'b1, 6'h04, 16'h0004, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[16] = '{1'b0, 1'b1, 6'h08, 16'h0000, 16'd4, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[17] = '{1'b0, 1'b0, 6'h00, 16'h0000, 16'd4, 1'b0, 1'b1, 1'b1, 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    r_drv    = '0;
    repeat (2) @(posedge ck);
    @(negedge ck);
    rst = 1'b0;
    #1;
    check("reset sig", 32'(sig), 32'h0);
    check("reset cnt", 32'(cnt), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    check("reset pass", 32'(pass), 32'h0);
    check("reset fb sig", 32'(sig_f), 32'h8000);

    // Feedback taps, START ignored in RUN, then abort with RST.
    drive(1'b1, 1'b0, 6'h00);
    check("start busy", 32'(busy), 32'h1);
    check("start fb seed", 32'(sig_f), 32'h8000);
    drive(1'b0, 1'b1, 6'h00);
    check("fb step sig", 32'(sig_f), 32'h002d);
    check("zero step sig", 32'(sig), 32'h0);
    check("zero step cnt", 32'(cnt), 32'h1);
    drive(1'b0, 1'b1, 6'h3f);
    check("cap2 sig", 32'(sig), 32'h003f);
    check("cap2 cnt", 32'(cnt), 32'h2);
    drive(1'b1, 1'b0, 6'h00);
    check("start in run sig", 32'(sig), 32'h003f);
    check("start in run cnt", 32'(cnt), 32'h2);
    @(negedge ck);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge ck);
    #1;
    check("abort sig", 32'(sig), 32'h0);
    check("abort cnt", 32'(cnt), 32'h0);
    check("abort busy", 32'(busy), 32'h0);
    check("abort done", 32'(done), 32'h0);
    check("abort fb sig", 32'(sig_f), 32'h8000);
    @(negedge ck);
    rst = 1'b0;

    for (int i = 0; i < NVec; i++) begin
      drive(tv[i].st, tv[i].iv, tv[i].r);
      check($sformatf("row%0d sig", i), 32'(sig), 32'(tv[i].sig));
      check($sformatf("row%0d cnt", i), 32'(cnt), 32'(tv[i].cnt));
      check($sformatf("row%0d busy", i), 32'(busy), 32'(tv[i].busy));
      check($sformatf("row%0d done", i), 32'(done), 32'(tv[i].done));
      check($sformatf("row%0d pass", i), 32'(pass), 32'(CmpEn & tv[i].pass));
      check($sformatf("row%0d pass_bad", i), 32'(pass_b), 32'(CmpEn & tv[i].pass_bad));
    end

    drive(1'b0, 1'b0, 6'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
